// File: rtl/epd_fsm_param_if.sv
// Byte-stream port bundle for epd_fsm_param: framed byte input plus frame-status outputs.
// Handshake: data is valid on every posedge where control=1; there is no ready/backpressure,
// and the first sampled control=0 after a run of 1s marks end-of-frame.
interface epd_fsm_param_if #(
  parameter int CNT_WIDTH = 4
);
  logic [7:0]           data;
  logic                 control;
  logic                 preamble_valid;
  logic                 dst_addr_valid;
  logic                 src_addr_valid;
  logic                 type_length_valid;
  logic                 packet_size_valid;
  logic                 frame_error;
  logic [CNT_WIDTH-1:0] valid_packet_counter;
  logic [CNT_WIDTH-1:0] error_counter;
  logic                 dst_match;
  logic [2:0]           state_dbg;

  modport master (
    output data, control,
    input  preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
    input  packet_size_valid, frame_error, valid_packet_counter, error_counter,
    input  dst_match, state_dbg
  );

  modport slave (
    input  data, control,
    output preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
    output packet_size_valid, frame_error, valid_packet_counter, error_counter,
    output dst_match, state_dbg
  );
endinterface

// File: rtl/epd_fsm_param.sv
// Ethernet packet detector: parses preamble/SFD/DST/SRC/type then counts payload, judges at EOF.
// Optional destination filter compiled in with `define EPD_DST_FILTER_EN.
module epd_fsm_param #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 46,
  parameter int MAX_PAYLOAD  = 1500,
  parameter int LENGTH_CHECK = 1,
  parameter int CNT_WIDTH    = 4,
  parameter int PLD_WIDTH    = 11
`ifdef EPD_DST_FILTER_EN
  ,
  // Station address only exists when the filter is built in.
  parameter logic [47:0] MAC_ADDR = 48'h010203040506
`endif
) (
  input logic            clock,
  input logic            reset,
  epd_fsm_param_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    DST     = 3'd2,
    SRC     = 3'd3,
    TYPE    = 3'd4,
    PAYLOAD = 3'd5,
    ERROR   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [15:0]          tl_q, tl_d;
  logic [PLD_WIDTH-1:0] pld_q, pld_d;
  logic                 pre_q, pre_d, dstv_q, dstv_d, srcv_q, srcv_d, tlv_q, tlv_d;
  logic                 psv_q, psv_d, ferr_q, ferr_d;
  logic [CNT_WIDTH-1:0] vcnt_q, vcnt_d, ecnt_q, ecnt_d;
  logic                 dm_q, dm_d, drop_q, drop_d;
`ifdef EPD_DST_FILTER_EN
  logic [47:0]          dst_q, dst_d;
  logic [47:0]          dst_full;
`endif

  logic [31:0] pld_ext, tl_ext;
  logic        len_ok, good;

  assign pld_ext = {{(32-PLD_WIDTH){1'b0}}, pld_q};
  assign tl_ext  = {16'h0000, tl_q};
  // Values above 1500 are EtherType codes, so only smaller ones constrain the payload count.
  assign len_ok  = (LENGTH_CHECK == 0) || (tl_ext > 32'd1500) || (pld_ext >= tl_ext);
  assign good    = (state_q == PAYLOAD) && (pld_ext >= 32'(MIN_PAYLOAD)) &&
                   (pld_ext <= 32'(MAX_PAYLOAD)) && len_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tl_d    = tl_q;
    pld_d   = pld_q;
    pre_d   = pre_q;
    dstv_d  = dstv_q;
    srcv_d  = srcv_q;
    tlv_d   = tlv_q;
    psv_d   = 1'b0;
    ferr_d  = 1'b0;
    vcnt_d  = vcnt_q;
    ecnt_d  = ecnt_q;
    dm_d    = dm_q;
    drop_d  = drop_q;
`ifdef EPD_DST_FILTER_EN
    dst_d    = dst_q;
    dst_full = {dst_q[39:0], bus.data};
`endif
    if (state_q == IDLE) begin
      pre_d  = 1'b0;
      dstv_d = 1'b0;
      srcv_d = 1'b0;
      tlv_d  = 1'b0;
      dm_d   = 1'b1;
      drop_d = 1'b0;
      cnt_d  = 8'd0;
      pld_d  = '0;
      if (bus.control) begin
        if (bus.data == 8'h55) begin
          state_d = PRE;
          cnt_d   = 8'd1;
        end else begin
          state_d = ERROR;
        end
      end
    end else if (!bus.control) begin
      state_d = IDLE;
      if (drop_q) begin
        // filtered frame: dropped silently
      end else if (good) begin
        psv_d  = 1'b1;
        vcnt_d = vcnt_q + 1'b1;
      end else begin
        ferr_d = 1'b1;
        if (ecnt_q != '1) ecnt_d = ecnt_q + 1'b1;
      end
    end else begin
      case (state_q)
        PRE: begin
          if (bus.data == 8'h55 && cnt_q < 8'(PREAMBLE_LEN)) begin
            cnt_d = cnt_q + 8'd1;
          end else if (bus.data == 8'hD5 && cnt_q == 8'(PREAMBLE_LEN)) begin
            pre_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = DST;
          end else begin
            state_d = ERROR;
          end
        end
        DST: begin
          cnt_d = cnt_q + 8'd1;
`ifdef EPD_DST_FILTER_EN
          dst_d = dst_full;
`endif
          if (cnt_q == 8'd5) begin
            cnt_d = 8'd0;
`ifdef EPD_DST_FILTER_EN
            dm_d = (dst_full == MAC_ADDR) || (dst_full == 48'hFFFF_FFFF_FFFF);
            if (dm_d) begin
              dstv_d  = 1'b1;
              state_d = SRC;
            end else begin
              drop_d  = 1'b1;
              state_d = ERROR;
            end
`else
            dstv_d  = 1'b1;
            state_d = SRC;
`endif
          end
        end
        SRC: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d   = 8'd0;
            srcv_d  = 1'b1;
            state_d = TYPE;
          end
        end
        TYPE: begin
          tl_d  = {tl_q[7:0], bus.data};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd1) begin
            cnt_d   = 8'd0;
            tlv_d   = 1'b1;
            pld_d   = '0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (pld_q != '1) pld_d = pld_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      tl_q    <= 16'd0;
      pld_q   <= '0;
      pre_q   <= 1'b0;
      dstv_q  <= 1'b0;
      srcv_q  <= 1'b0;
      tlv_q   <= 1'b0;
      psv_q   <= 1'b0;
      ferr_q  <= 1'b0;
      vcnt_q  <= '0;
      ecnt_q  <= '0;
      dm_q    <= 1'b1;
      drop_q  <= 1'b0;
`ifdef EPD_DST_FILTER_EN
      dst_q   <= 48'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tl_q    <= tl_d;
      pld_q   <= pld_d;
      pre_q   <= pre_d;
      dstv_q  <= dstv_d;
      srcv_q  <= srcv_d;
      tlv_q   <= tlv_d;
      psv_q   <= psv_d;
      ferr_q  <= ferr_d;
      vcnt_q  <= vcnt_d;
      ecnt_q  <= ecnt_d;
      dm_q    <= dm_d;
      drop_q  <= drop_d;
`ifdef EPD_DST_FILTER_EN
      dst_q   <= dst_d;
`endif
    end
  end

  assign bus.preamble_valid       = pre_q;
  assign bus.dst_addr_valid       = dstv_q;
  assign bus.src_addr_valid       = srcv_q;
  assign bus.type_length_valid    = tlv_q;
  assign bus.packet_size_valid    = psv_q;
  assign bus.frame_error          = ferr_q;
  assign bus.valid_packet_counter = vcnt_q;
  assign bus.error_counter        = ecnt_q;
`ifdef EPD_DST_FILTER_EN
  assign bus.dst_match            = dm_q;
`else
  assign bus.dst_match            = 1'b1;
`endif
  assign bus.state_dbg            = state_q;

endmodule
